// File: rtl/hci_cpuif_arb.sv
// Two-requester round-robin arbiter in front of the I3C CSR cpuif port.
// One outstanding transaction; acks are routed to the issuer; a watchdog turns a lost ack into an error.
module hci_cpuif_arb #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,

   input  logic                  m0_req,
   input  logic                  m0_req_is_wr,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wr_data,
   input  logic [DATA_WIDTH-1:0] m0_wr_biten,
   output logic                  m0_req_stall_wr,
   output logic                  m0_req_stall_rd,
   output logic                  m0_rd_ack,
   output logic                  m0_rd_err,
   output logic [DATA_WIDTH-1:0] m0_rd_data,
   output logic                  m0_wr_ack,
   output logic                  m0_wr_err,

   input  logic                  m1_req,
   input  logic                  m1_req_is_wr,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wr_data,
   input  logic [DATA_WIDTH-1:0] m1_wr_biten,
   output logic                  m1_req_stall_wr,
   output logic                  m1_req_stall_rd,
   output logic                  m1_rd_ack,
   output logic                  m1_rd_err,
   output logic [DATA_WIDTH-1:0] m1_rd_data,
   output logic                  m1_wr_ack,
   output logic                  m1_wr_err,

   output logic                  s_cpuif_req,
   output logic                  s_cpuif_req_is_wr,
   output logic [ADDR_WIDTH-1:0] s_cpuif_addr,
   output logic [DATA_WIDTH-1:0] s_cpuif_wr_data,
   output logic [DATA_WIDTH-1:0] s_cpuif_wr_biten,
   input  logic                  s_cpuif_req_stall_wr,
   input  logic                  s_cpuif_req_stall_rd,
   input  logic                  s_cpuif_rd_ack,
   input  logic                  s_cpuif_rd_err,
   input  logic [DATA_WIDTH-1:0] s_cpuif_rd_data,
   input  logic                  s_cpuif_wr_ack,
   input  logic                  s_cpuif_wr_err
);

   // state | meaning
   // IDLE  | arbitrating; winner's request passes straight through to the CSR block
   // BUSY  | one transaction outstanding for owner_q; waiting for ack or watchdog expiry

   localparam int WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit WDOG_EN = (TIMEOUT > 0);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                rr_prio_q, rr_prio_d;
   logic                is_wr_q, is_wr_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;

   logic                any_req;
   logic                winner;
   logic                w_is_wr;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic [DATA_WIDTH-1:0] w_wr_biten;
   logic                accept;
   logic                done;
   logic                timeout;

   logic                rt_rd_ack;
   logic                rt_rd_err;
   logic [DATA_WIDTH-1:0] rt_rd_data;
   logic                rt_wr_ack;
   logic                rt_wr_err;

   assign any_req    = m0_req | m1_req;
   assign winner     = (m0_req & m1_req) ? rr_prio_q : m1_req;
   assign w_is_wr    = winner ? m1_req_is_wr : m0_req_is_wr;
   assign w_addr     = winner ? m1_addr      : m0_addr;
   assign w_wr_data  = winner ? m1_wr_data   : m0_wr_data;
   assign w_wr_biten = winner ? m1_wr_biten  : m0_wr_biten;

   assign accept  = any_req & ~(w_is_wr ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd);
   assign done    = s_cpuif_rd_ack | s_cpuif_wr_ack;
   // A real ack in the expiry cycle wins over the watchdog.
   assign timeout = WDOG_EN & (wdog_q == WDOG_LAST) & ~done;

   assign rt_rd_ack  = s_cpuif_rd_ack | (timeout & ~is_wr_q);
   assign rt_rd_err  = s_cpuif_rd_err | (timeout & ~is_wr_q);
   assign rt_rd_data = s_cpuif_rd_ack ? s_cpuif_rd_data : '0;
   assign rt_wr_ack  = s_cpuif_wr_ack | (timeout & is_wr_q);
   assign rt_wr_err  = s_cpuif_wr_err | (timeout & is_wr_q);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         rr_prio_q <= 1'b0;
         is_wr_q   <= 1'b0;
         wdog_q    <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         rr_prio_q <= rr_prio_d;
         is_wr_q   <= is_wr_d;
         wdog_q    <= wdog_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_prio_d = rr_prio_q;
      is_wr_d   = is_wr_q;
      wdog_d    = wdog_q;

      s_cpuif_req       = 1'b0;
      s_cpuif_req_is_wr = 1'b0;
      s_cpuif_addr      = '0;
      s_cpuif_wr_data   = '0;
      s_cpuif_wr_biten  = '0;

      m0_req_stall_wr = 1'b1;
      m0_req_stall_rd = 1'b1;
      m0_rd_ack       = 1'b0;
      m0_rd_err       = 1'b0;
      m0_rd_data      = '0;
      m0_wr_ack       = 1'b0;
      m0_wr_err       = 1'b0;

      m1_req_stall_wr = 1'b1;
      m1_req_stall_rd = 1'b1;
      m1_rd_ack       = 1'b0;
      m1_rd_err       = 1'b0;
      m1_rd_data      = '0;
      m1_wr_ack       = 1'b0;
      m1_wr_err       = 1'b0;

      // Outputs are held quiet while reset is asserted; acks seen in IDLE are stray and dropped.
      if (rst_ni) begin
         if (state_q == IDLE) begin
            s_cpuif_req       = any_req;
            s_cpuif_req_is_wr = w_is_wr;
            s_cpuif_addr      = w_addr;
            s_cpuif_wr_data   = w_wr_data;
            s_cpuif_wr_biten  = w_wr_biten;
            if (winner) begin
               m1_req_stall_wr = s_cpuif_req_stall_wr;
               m1_req_stall_rd = s_cpuif_req_stall_rd;
            end else begin
               m0_req_stall_wr = s_cpuif_req_stall_wr;
               m0_req_stall_rd = s_cpuif_req_stall_rd;
            end
            if (accept) begin
               state_d   = BUSY;
               owner_d   = winner;
               rr_prio_d = ~winner;
               is_wr_d   = w_is_wr;
               wdog_d    = '0;
            end
         end else begin
            if (owner_q) begin
               m1_rd_ack  = rt_rd_ack;
               m1_rd_err  = rt_rd_err;
               m1_rd_data = rt_rd_data;
               m1_wr_ack  = rt_wr_ack;
               m1_wr_err  = rt_wr_err;
            end else begin
               m0_rd_ack  = rt_rd_ack;
               m0_rd_err  = rt_rd_err;
               m0_rd_data = rt_rd_data;
               m0_wr_ack  = rt_wr_ack;
               m0_wr_err  = rt_wr_err;
            end
            if (done || timeout) begin
               state_d = IDLE;
            end else if (WDOG_EN) begin
               wdog_d = wdog_q + WDOG_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_hci_cpuif_arb.sv
// Bench for hci_cpuif_arb: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of grant order, ownership and ack age.
module tb_hci_cpuif_arb;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int TO = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic [1:0]          r_req, r_wr;
   logic [1:0][AW-1:0]  r_addr;
   logic [1:0][DW-1:0]  r_wdata, r_biten;
   logic [1:0]          o_stall_wr, o_stall_rd, o_rd_ack, o_rd_err, o_wr_ack, o_wr_err;
   logic [1:0][DW-1:0]  o_rd_data;
   logic                s_req, s_wr;
   logic [AW-1:0]       s_addr;
   logic [DW-1:0]       s_wdata, s_biten;
   logic                d_stall_wr, d_stall_rd, d_rd_ack, d_rd_err, d_wr_ack, d_wr_err;
   logic [DW-1:0]       d_rd_data;
   logic [DW-1:0]       ds_data;

   hci_cpuif_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_req(r_req[0]), .m0_req_is_wr(r_wr[0]), .m0_addr(r_addr[0]),
      .m0_wr_data(r_wdata[0]), .m0_wr_biten(r_biten[0]),
      .m0_req_stall_wr(o_stall_wr[0]), .m0_req_stall_rd(o_stall_rd[0]),
      .m0_rd_ack(o_rd_ack[0]), .m0_rd_err(o_rd_err[0]), .m0_rd_data(o_rd_data[0]),
      .m0_wr_ack(o_wr_ack[0]), .m0_wr_err(o_wr_err[0]),
      .m1_req(r_req[1]), .m1_req_is_wr(r_wr[1]), .m1_addr(r_addr[1]),
      .m1_wr_data(r_wdata[1]), .m1_wr_biten(r_biten[1]),
      .m1_req_stall_wr(o_stall_wr[1]), .m1_req_stall_rd(o_stall_rd[1]),
      .m1_rd_ack(o_rd_ack[1]), .m1_rd_err(o_rd_err[1]), .m1_rd_data(o_rd_data[1]),
      .m1_wr_ack(o_wr_ack[1]), .m1_wr_err(o_wr_err[1]),
      .s_cpuif_req(s_req), .s_cpuif_req_is_wr(s_wr), .s_cpuif_addr(s_addr),
      .s_cpuif_wr_data(s_wdata), .s_cpuif_wr_biten(s_biten),
      .s_cpuif_req_stall_wr(d_stall_wr), .s_cpuif_req_stall_rd(d_stall_rd),
      .s_cpuif_rd_ack(d_rd_ack), .s_cpuif_rd_err(d_rd_err), .s_cpuif_rd_data(d_rd_data),
      .s_cpuif_wr_ack(d_wr_ack), .s_cpuif_wr_err(d_wr_err)
   );

   // Reference model: busy flag, owner, tie-break favourite, direction, cycles since acceptance.
   bit m_busy = 1'b0, m_owner = 1'b0, m_prio = 1'b0, m_dir = 1'b0;
   bit m_acc = 1'b0, m_win = 1'b0, m_done = 1'b0;
   int m_age = 0;
   int n_vec = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cycle();
      bit w, anyr, ack, to;
      @(negedge clk);
      m_acc  = 1'b0;
      m_done = 1'b0;
      if (!rst_n) begin
         chk("rst_s_req", s_req, 1'b0);
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_m%0d_stall_wr", i), o_stall_wr[i], 1'b1);
            chk($sformatf("rst_m%0d_stall_rd", i), o_stall_rd[i], 1'b1);
            chk($sformatf("rst_m%0d_acks", i), {o_rd_ack[i], o_rd_err[i], o_wr_ack[i], o_wr_err[i]}, 4'b0);
            chk($sformatf("rst_m%0d_rd_data", i), o_rd_data[i], '0);
         end
      end else if (!m_busy) begin
         anyr = r_req[0] | r_req[1];
         w = (r_req[0] && r_req[1]) ? m_prio : r_req[1];
         chk("idle_s_req", s_req, anyr);
         if (anyr) begin
            chk("s_is_wr", s_wr, r_wr[w]);
            chk("s_addr", s_addr, r_addr[w]);
            chk("s_wr_data", s_wdata, r_wdata[w]);
            chk("s_wr_biten", s_biten, r_biten[w]);
            for (int i = 0; i < 2; i++) begin
               if (r_req[i]) begin
                  chk($sformatf("m%0d_stall_wr", i), o_stall_wr[i], (i == int'(w)) ? d_stall_wr : 1'b1);
                  chk($sformatf("m%0d_stall_rd", i), o_stall_rd[i], (i == int'(w)) ? d_stall_rd : 1'b1);
               end
            end
            m_acc = !(r_wr[w] ? d_stall_wr : d_stall_rd);
            m_win = w;
         end
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("idle_m%0d_acks", i), {o_rd_ack[i], o_rd_err[i], o_wr_ack[i], o_wr_err[i]}, 4'b0);
            chk($sformatf("idle_m%0d_rd_data", i), o_rd_data[i], '0);
         end
      end else begin
         chk("busy_s_req", s_req, 1'b0);
         chk("busy_stalls", {o_stall_wr, o_stall_rd}, 4'hF);
         ack = d_rd_ack | d_wr_ack;
         to  = !ack && (m_age == TO);
         m_done = ack | to;
         for (int i = 0; i < 2; i++) begin
            if (i == int'(m_owner)) begin
               chk($sformatf("m%0d_rd_ack", i), o_rd_ack[i], d_rd_ack | (to & ~m_dir));
               chk($sformatf("m%0d_rd_err", i), o_rd_err[i], d_rd_err | (to & ~m_dir));
               chk($sformatf("m%0d_wr_ack", i), o_wr_ack[i], d_wr_ack | (to & m_dir));
               chk($sformatf("m%0d_wr_err", i), o_wr_err[i], d_wr_err | (to & m_dir));
               chk($sformatf("m%0d_rd_data", i), o_rd_data[i], d_rd_ack ? d_rd_data : '0);
            end else begin
               chk($sformatf("nonowner_m%0d_acks", i), {o_rd_ack[i], o_rd_err[i], o_wr_ack[i], o_wr_err[i]}, 4'b0);
               chk($sformatf("nonowner_m%0d_rd_data", i), o_rd_data[i], '0);
            end
         end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
         m_busy = 1'b0; m_owner = 1'b0; m_prio = 1'b0;
      end else if (!m_busy) begin
         if (m_acc) begin
            m_busy = 1'b1; m_owner = m_win; m_prio = !m_win; m_age = 1; m_dir = r_wr[m_win];
         end
      end else if (m_done) begin
         m_busy = 1'b0;
      end else begin
         m_age++;
      end
   endtask

   // Directed runner: downstream acks at a fixed count of cycles after acceptance.
   task automatic run(input int n, input int ack_at, input int stall_n, input bit keep);
      int since = -1000;
      int st = stall_n;
      repeat (n) begin
         d_stall_wr = (st > 0);
         d_stall_rd = (st > 0);
         d_rd_ack = 1'b0; d_wr_ack = 1'b0; d_rd_err = 1'b0; d_wr_err = 1'b0;
         d_rd_data = ds_data;
         if (since == ack_at) begin
            if (m_dir) d_wr_ack = 1'b1;
            else       d_rd_ack = 1'b1;
         end
         cycle();
         if (st > 0) st--;
         since++;
         if (m_acc) begin
            since = 1;
            if (!keep) r_req[m_win] = 1'b0;
         end
      end
   endtask

   task automatic set_req(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      r_req[i] = 1'b1; r_wr[i] = wr; r_addr[i] = a; r_wdata[i] = d; r_biten[i] = '1;
   endtask

   initial begin
      int ack_at;
      rst_n = 1'b0;
      r_req = '0; r_wr = '0; r_addr = '0; r_wdata = '0; r_biten = '0;
      d_stall_wr = 1'b0; d_stall_rd = 1'b0; d_rd_ack = 1'b0; d_rd_err = 1'b0;
      d_wr_ack = 1'b0; d_wr_err = 1'b0; d_rd_data = '0; ds_data = '0;
      cycle();
      cycle();
      rst_n = 1'b1;

      // m0 read, data returned two cycles after acceptance
      ds_data = 32'hA5A5_0001;
      set_req(0, 1'b0, 12'h010, '0);
      run(6, 2, 0, 1'b0);

      // both requesting continuously from reset: grants alternate m0, m1, ...
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      set_req(0, 1'b0, 12'h100, '0);
      set_req(1, 1'b0, 12'h200, '0);
      ds_data = 32'h1234_5678;
      run(12, 1, 0, 1'b1);
      r_req = '0;
      run(3, 1, 0, 1'b0);

      // m1 write stalled for three cycles
      set_req(1, 1'b1, 12'h020, 32'hDEAD_BEEF);
      run(8, 2, 3, 1'b0);

      // watchdog expiry, then a late stray ack
      set_req(0, 1'b0, 12'h030, '0);
      ds_data = 32'hCAFE_0003;
      run(14, 10, 0, 1'b0);

      // ack in the watchdog's last cycle wins
      set_req(0, 1'b0, 12'h040, '0);
      run(12, 8, 0, 1'b0);

      // reset while busy, then m1 granted
      set_req(0, 1'b0, 12'h050, '0);
      run(3, 100, 0, 1'b0);
      rst_n = 1'b0;
      d_rd_ack = 1'b0; d_wr_ack = 1'b0;
      cycle();
      rst_n = 1'b1;
      set_req(1, 1'b1, 12'h060, 32'h0BAD_F00D);
      run(6, 2, 0, 1'b0);

      // random traffic
      ack_at = 1;
      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (!r_req[i] && $urandom_range(0, 9) < 4) begin
               r_req[i]   = 1'b1;
               r_wr[i]    = 1'($urandom);
               r_addr[i]  = AW'($urandom);
               r_wdata[i] = DW'($urandom);
               r_biten[i] = DW'($urandom);
            end
         end
         d_stall_wr = ($urandom_range(0, 3) == 0);
         d_stall_rd = ($urandom_range(0, 3) == 0);
         d_rd_data  = DW'($urandom);
         d_rd_ack = 1'b0; d_wr_ack = 1'b0; d_rd_err = 1'b0; d_wr_err = 1'b0;
         if (m_busy && m_age == ack_at) begin
            if (m_dir) begin d_wr_ack = 1'b1; d_wr_err = 1'($urandom); end
            else       begin d_rd_ack = 1'b1; d_rd_err = 1'($urandom); end
         end else if (!m_busy && $urandom_range(0, 9) == 0) begin
            d_rd_ack = 1'b1;
            d_wr_ack = 1'($urandom);
         end
         cycle();
         if (m_acc) begin
            r_req[m_win] = 1'b0;
            ack_at = $urandom_range(1, 10);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/hci_cpuif_arb.md
# hci_cpuif_arb

Two-requester arbiter for the single register-access (cpuif) port of the I3C CSR block inside the host controller interface. It lets the AHB front-end (requester 0) and a second internal master such as a DMA or debug/test port (requester 1) share the CSR block. Arbitration is round-robin with one outstanding transaction at a time. Each acknowledgement is routed back to the requester that issued the transaction. A watchdog converts a missing acknowledgement into an error response.

## Interface
- ADDR_WIDTH, 12: CSR byte-address width; matches the CSR block minimum address width.
- DATA_WIDTH, 32: CSR data width.
- TIMEOUT, 255: cycles to wait for an acknowledgement before an error response is generated; 0 disables the watchdog.
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset; synchronous, active-low.
- m0_req, m1_req  in  1  request from requester n (below, mN_* means m0_* and m1_*).
- mN_req_is_wr  in  1  write when 1, read when 0.
- mN_addr  in  ADDR_WIDTH  address.
- mN_wr_data, mN_wr_biten  in  DATA_WIDTH  write data and bit enables.
- mN_req_stall_wr, mN_req_stall_rd  out  1  requester n must hold its request.
- mN_rd_ack, mN_rd_err  out  1  read completion and error, pulsed.
- mN_rd_data  out  DATA_WIDTH  read data; valid with mN_rd_ack, 0 otherwise.
- mN_wr_ack, mN_wr_err  out  1  write completion and error, pulsed.
- s_cpuif_req, s_cpuif_req_is_wr, s_cpuif_addr, s_cpuif_wr_data, s_cpuif_wr_biten  out  1/1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH  request to the CSR block.
- s_cpuif_req_stall_wr, s_cpuif_req_stall_rd  in  1  stall from the CSR block.
- s_cpuif_rd_ack, s_cpuif_rd_err, s_cpuif_rd_data, s_cpuif_wr_ack, s_cpuif_wr_err  in  1/1/DATA_WIDTH/1/1  completion from the CSR block.

## Operation
- The FSM has two states: IDLE and BUSY. Registered state:
  - state
  - owner (1 bit)
  - rr_prio (1 bit; the requester that wins a tie)
  - wdog counter, width clog2(TIMEOUT+1)
- IDLE grant rule:
  - If only one requester has req high, it wins.
  - If both do, rr_prio wins.
  - The winner's request fields pass combinationally to s_cpuif_*.
  - The loser sees both of its stalls at 1.
  - The winner's stalls mirror s_cpuif_req_stall_wr/rd.
- Acceptance means, in IDLE, s_cpuif_req=1 and the stall for that direction is 0. On the next edge:
  - state becomes BUSY;
  - owner becomes the winner;
  - rr_prio becomes the other requester;
  - wdog is cleared.
- If the winner's request is stalled, nothing is registered and arbitration is re-evaluated every cycle. A requester may not withdraw a request while it is stalled.
- BUSY:
  - s_cpuif_req=0, and all four mN_req_stall_* are 1.
  - s_cpuif_rd_ack/rd_err/rd_data/wr_ack/wr_err are routed combinationally to the owner only. The non-owner's ack and err outputs are 0 and its rd_data is 0.
  - On any ack (rd or wr), the next state is IDLE. New requests are stalled during the ack cycle.
  - If TIMEOUT>0 and there has been no ack, wdog increments each cycle.
  - When wdog==TIMEOUT-1 with no ack, the owner receives ack=1 and err=1 for the transaction's direction, with rd_data=0, and the next state is IDLE.
  - The direction is held in a registered is_wr bit captured at acceptance.
- A downstream ack in IDLE is stray (e.g. a late ack after a timeout). It is dropped and not forwarded to any requester.
- An ack and a timeout in the same cycle: the real ack wins and the timeout error is not raised.

## Timing
- Request pass-through latency is 0 cycles (combinational) in IDLE.
- Acknowledgement routing latency is 0 cycles.
- Back-to-back throughput is one transaction per (downstream latency + 1) cycles minimum, because the ack cycle is always followed by an IDLE cycle.
- Reset values (rst_ni low at the edge):
  - state=IDLE, owner=0, rr_prio=0 (m0 favoured), wdog=0.
- While rst_ni is low:
  - s_cpuif_req=0;
  - all mN_req_stall_*=1;
  - all mN ack, err and rd_data outputs = 0.
- Reset mid-transaction: return to IDLE immediately. Any ack arriving after reset is treated as stray and dropped.
- A timeout error pulse is exactly 1 cycle, TIMEOUT cycles after the acceptance edge.

## Test plan
- m0 read, addr 0x010, downstream rd_ack with data 0xA5A5_0001 two cycles later -> m0_rd_ack=1 with that data; m1 outputs stay 0.
- m0 and m1 both request continuously, with a 1-cycle ack each time -> grants out of reset go m0, m1, m0, m1. Each ack reaches only its issuer.
- m1 write, 0xDEAD_BEEF to 0x020, with s_cpuif_req_stall_wr=1 for 3 cycles -> m1 sees its stall for those 3 cycles; accepted on cycle 4; m1_wr_ack after the downstream ack.
- TIMEOUT=8, m0 read with no ack -> m0_rd_ack=1, m0_rd_err=1, rd_data=0 exactly 8 cycles after acceptance. A downstream rd_ack on cycle 10 is dropped.
- rst_ni low for one cycle while BUSY -> IDLE on the next cycle; stalls are 1 during reset; a following m1 request is granted (rr_prio=0, m0 idle).
- Ack on the same cycle that wdog reaches TIMEOUT-1 -> the normal ack is forwarded with err=0.
